// File: rtl/eeprom_iic_arbiter.sv
// eeprom_iic_arbiter: shares one iic_com EEPROM byte engine between two
// requesters. Round-robin grant, Start_Sig/Done_Sig sequencing and an
// enforced post-write idle time (tWR) before the next grant.
// Optional build macro IIC_TIMEOUT_EN adds a Done_Sig watchdog and the
// timeout_err output; without it WAIT waits for iic_done indefinitely.
module eeprom_iic_arbiter #(
  parameter int WR_CYCLES      = 1000000,
  parameter int CNT_W          = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0,
  input  logic       rw0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       done0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       rw1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       done1,
  output logic [7:0] rdata1,
  output logic [1:0] iic_start,
  output logic [7:0] iic_addr,
  output logic [7:0] iic_wdata,
  input  logic [7:0] iic_rdata,
  input  logic       iic_done,
  output logic       busy,
  output logic       gnt
`ifdef IIC_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2,
    S_WR_DLY  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  // Reject parameter sets the counter cannot represent
  generate
    if (WR_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        CNT_W < $clog2(WR_CYCLES + 1) || CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_params
      $error("eeprom_iic_arbiter: WR_CYCLES/TIMEOUT_CYCLES must be >= 1 and fit in CNT_W bits");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [1:0]       req_vec;
  logic [1:0]       armed_reg;
  logic [1:0]       elig;
  logic             rr_reg;
  logic             gnt_reg;
  logic             rw_reg;
  logic [1:0]       iic_start_reg;
  logic [7:0]       iic_addr_reg;
  logic [7:0]       iic_wdata_reg;
  logic [7:0]       rdata_reg [2];
  logic [CNT_W-1:0] cnt_reg;

  logic             grant_valid;
  logic             grant_idx;
  logic             grant_rw;
  logic [7:0]       grant_addr;
  logic [7:0]       grant_wdata;
  logic             grant_fire;
  logic             wait_done;
  logic             wait_expired;
  logic             timed_out;

  assign req_vec    = {req1, req0};
  assign grant_fire = (state_reg == S_IDLE) && grant_valid;
  assign wait_done  = (state_reg == S_WAIT) && iic_done;

`ifdef IIC_TIMEOUT_EN
  localparam bit               TO_EN   = 1'b1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timed_out_reg;

  // Watchdog fires on the last allowed WAIT cycle if iic_done never came
  assign wait_expired = (state_reg == S_WAIT) && !iic_done && (cnt_reg == TO_LAST);

  // Remember that the current transaction ended by timeout until RELEASE ends
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timed_out_reg <= 1'b0;
    end else if (wait_expired) begin
      timed_out_reg <= 1'b1;
    end else if (state_reg == S_RELEASE) begin
      timed_out_reg <= 1'b0;
    end
  end

  assign timed_out   = timed_out_reg;
  assign timeout_err = (state_reg == S_RELEASE) && timed_out_reg;
`else
  localparam bit TO_EN = 1'b0;
  assign wait_expired = 1'b0;
  assign timed_out    = 1'b0;
`endif

  // Pick the requester to serve: round-robin pointer breaks ties
  always_comb begin
    elig        = req_vec & armed_reg;
    grant_valid = |elig;
    grant_idx   = (&elig) ? rr_reg : elig[1];
    grant_rw    = grant_idx ? rw1    : rw0;
    grant_addr  = grant_idx ? addr1  : addr0;
    grant_wdata = grant_idx ? wdata1 : wdata0;
  end

  // Per-requester arming and read-data holding registers
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      // Re-arm whenever req is low; disarm on grant so a held req is not re-served
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          armed_reg[gi] <= 1'b0;
        end else if (!req_vec[gi]) begin
          armed_reg[gi] <= 1'b1;
        end else if (grant_fire && (grant_idx == gi[0])) begin
          armed_reg[gi] <= 1'b0;
        end
      end

      // Read byte lands on the edge into RELEASE so it coincides with done
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rdata_reg[gi] <= 8'h00;
        end else if (wait_done && rw_reg && (gnt_reg == gi[0])) begin
          rdata_reg[gi] <= iic_rdata;
        end
      end
    end
  endgenerate

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (grant_valid) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iic_done || wait_expired) begin
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!rw_reg && !timed_out) begin
          state_next = S_WR_DLY;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WR_DLY: begin
        if (cnt_reg == '0) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy and the one-cycle done pulse of the owning requester
  always_comb begin
    busy  = (state_reg != S_IDLE);
    done0 = 1'b0;
    done1 = 1'b0;
    if (state_reg == S_RELEASE) begin
      if (gnt_reg) begin
        done1 = 1'b1;
      end else begin
        done0 = 1'b1;
      end
    end
  end

  // Transaction latch: command registers load at grant, Start_Sig drops on completion
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iic_start_reg <= 2'b00;
      iic_addr_reg  <= 8'h00;
      iic_wdata_reg <= 8'h00;
      rw_reg        <= 1'b0;
      gnt_reg       <= 1'b0;
      rr_reg        <= 1'b0;
    end else begin
      if (grant_fire) begin
        iic_start_reg <= grant_rw ? 2'b10 : 2'b01;
        iic_addr_reg  <= grant_addr;
        iic_wdata_reg <= grant_wdata;
        rw_reg        <= grant_rw;
        gnt_reg       <= grant_idx;
        rr_reg        <= ~grant_idx;
      end else if (wait_done || wait_expired) begin
        iic_start_reg <= 2'b00;
      end
    end
  end

  // Shared counter: watchdog in WAIT, tWR countdown in WR_DLY
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_valid) begin
            cnt_reg <= '0;
          end
        end
        S_WAIT: begin
          if (TO_EN && !iic_done) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!rw_reg && !timed_out) begin
            cnt_reg <= WR_LAST;
          end
        end
        S_WR_DLY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

  assign iic_start = iic_start_reg;
  assign iic_addr  = iic_addr_reg;
  assign iic_wdata = iic_wdata_reg;
  assign gnt       = gnt_reg;
  assign rdata0    = rdata_reg[0];
  assign rdata1    = rdata_reg[1];

endmodule

// File: tb/tb_eeprom_iic_arbiter.sv
// Bench for eeprom_iic_arbiter: an iic_com behavioural model with a small
// EEPROM array, directed requester stimulus, and a negedge monitor that
// pops expected transactions from a queue on every Start and done event.
module tb_eeprom_iic_arbiter;

  localparam int WR_CYCLES      = 100;
  localparam int CNT_W          = 20;
  localparam int TIMEOUT_CYCLES = 200;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       done0, done1, busy, gnt, iic_done;
  logic [7:0] rdata0, rdata1, iic_addr, iic_wdata, iic_rdata;
  logic [1:0] iic_start;
`ifdef IIC_TIMEOUT_EN
  logic       timeout_err;
`endif

  eeprom_iic_arbiter #(
    .WR_CYCLES(WR_CYCLES), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
`ifdef IIC_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .CLK(CLK), .RST(RST),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .iic_start(iic_start), .iic_addr(iic_addr), .iic_wdata(iic_wdata),
    .iic_rdata(iic_rdata), .iic_done(iic_done), .busy(busy), .gnt(gnt)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- scoreboard queue ----------------
  typedef struct {
    logic       who;
    logic [1:0] start;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input logic who, input logic [1:0] start, input logic [7:0] addr,
                      input logic [7:0] wdata, input logic [7:0] rdata);
    exp_t e;
    e.who = who; e.start = start; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // ---------------- iic_com model ----------------
  logic [7:0] mem [256];
  int         model_lat = 50;

  initial begin
    bit aborted;
    for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
    iic_done  = 1'b0;
    iic_rdata = 8'h00;
    forever begin
      @(negedge CLK);
      if (!RST && iic_start != 2'b00) begin
        aborted = 1'b0;
        for (int k = 0; k < model_lat; k++) begin
          @(negedge CLK);
          if (iic_start == 2'b00) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          if (iic_start == 2'b01) mem[iic_addr] = iic_wdata;
          else iic_rdata = mem[iic_addr];
          iic_done = 1'b1;
          @(negedge CLK);
          iic_done = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t       cur;
  bit         cur_valid = 0;
  logic [1:0] prev_start = 2'b00;
  logic [7:0] sh_rdata0 = 8'h00, sh_rdata1 = 8'h00;
  bit         meas = 0, pulse_chk = 0;
  int         meas_cnt = 0, meas_exp = 0;

  always @(negedge CLK) begin
    if (RST) begin
      cur_valid  = 0;
      prev_start = 2'b00;
      sh_rdata0  = 8'h00;
      sh_rdata1  = 8'h00;
      meas       = 0;
      pulse_chk  = 0;
    end else begin
      if (pulse_chk) begin
        check("done_width", {30'd0, done1, done0}, 32'd0);
        pulse_chk = 0;
      end
      if (meas) begin
        if (busy) meas_cnt++;
        else begin
          check("busy_after_done", meas_cnt, meas_exp);
          meas = 0;
        end
      end
      if (prev_start == 2'b00 && iic_start != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", {30'd0, iic_start}, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("start_gnt", gnt, cur.who);
          check("start_code", iic_start, cur.start);
          check("start_addr", iic_addr, cur.addr);
          check("start_wdata", iic_wdata, cur.wdata);
          check("start_busy", busy, 1);
          cur_valid = 1;
        end
      end
      if (done0 || done1) begin
        if (!cur_valid) begin
          check("unexpected_done", {30'd0, done1, done0}, 32'd0);
        end else begin
          check("done_who", {30'd0, done1, done0}, cur.who ? 32'd2 : 32'd1);
          check("release_start", iic_start, 2'b00);
          if (cur.start == 2'b10) begin
            if (cur.who) sh_rdata1 = cur.rdata;
            else sh_rdata0 = cur.rdata;
          end
          check("rdata0", rdata0, sh_rdata0);
          check("rdata1", rdata1, sh_rdata1);
          meas      = 1;
          meas_cnt  = 0;
          meas_exp  = (cur.start == 2'b01) ? WR_CYCLES : 0;
          pulse_chk = 1;
          cur_valid = 0;
        end
      end
      prev_start = iic_start;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input logic who, input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge CLK);
      if (who ? done1 : done0) return;
    end
    check("wait_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_any(output logic who, input int limit);
    who = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge CLK);
      if (done0 || done1) begin
        who = done1;
        return;
      end
    end
    check("wait_any_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge CLK);
      if (!busy) return;
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic who;
    int   bad, hold;

    repeat (3) @(negedge CLK);
    check("rst_start", iic_start, 2'b00);
    check("rst_addr", iic_addr, 8'h00);
    check("rst_wdata", iic_wdata, 8'h00);
    check("rst_done", {30'd0, done1, done0}, 32'd0);
    check("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", gnt, 1'b0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // single write from requester 0
    push(1'b0, 2'b01, 8'h00, 8'h12, 8'h00);
    rw0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h12; req0 = 1'b1;
    wait_done(1'b0, 200);
    req0 = 1'b0;
    wait_idle(300);

    // read-back by requester 1
    push(1'b1, 2'b10, 8'h00, 8'h77, 8'h12);
    rw1 = 1'b1; addr1 = 8'h00; wdata1 = 8'h77; req1 = 1'b1;
    wait_done(1'b1, 200);
    req1 = 1'b0;
    wait_idle(50);

    // simultaneous reads, both re-arming: order 0,1,0,1
    model_lat = 5;
    rw0 = 1'b1; addr0 = 8'h00; wdata0 = 8'h21;
    rw1 = 1'b1; addr1 = 8'h05; wdata1 = 8'h43;
    push(1'b0, 2'b10, 8'h00, 8'h21, 8'h12);
    push(1'b1, 2'b10, 8'h05, 8'h43, 8'hFA);
    push(1'b0, 2'b10, 8'h00, 8'h21, 8'h12);
    push(1'b1, 2'b10, 8'h05, 8'h43, 8'hFA);
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_any(who, 200);
      if (who) req1 = 1'b0; else req0 = 1'b0;
      @(negedge CLK);
      if (t < 2) begin
        if (who) req1 = 1'b1; else req0 = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle(50);

    // write delay blocks requester 1 until the first IDLE cycle
    model_lat = 10;
    rw0 = 1'b0; addr0 = 8'h33; wdata0 = 8'h5C;
    rw1 = 1'b1; addr1 = 8'h33; wdata1 = 8'h66;
    push(1'b0, 2'b01, 8'h33, 8'h5C, 8'h00);
    push(1'b1, 2'b10, 8'h33, 8'h66, 8'h5C);
    req0 = 1'b1;
    wait_done(1'b0, 100);
    req0 = 1'b0;
    @(negedge CLK);
    req1 = 1'b1;
    bad = 0;
    for (int n = 0; n < 500 && busy; n++) begin
      if (iic_start != 2'b00) bad++;
      @(negedge CLK);
    end
    check("wrdly_no_start", bad, 0);
    check("wrdly_idle_busy", busy, 1'b0);
    check("wrdly_idle_start", iic_start, 2'b00);
    @(negedge CLK);
    check("wrdly_first_idle_grant", iic_start, 2'b10);
    wait_done(1'b1, 100);
    req1 = 1'b0;
    wait_idle(50);

    // re-arm rule: held req is not re-granted
    rw0 = 1'b1; addr0 = 8'h05; wdata0 = 8'h00;
    push(1'b0, 2'b10, 8'h05, 8'h00, 8'hFA);
    req0 = 1'b1;
    wait_done(1'b0, 100);
    hold = 0;
    repeat (20) begin
      @(negedge CLK);
      if (busy) hold++;
    end
    check("rearm_held_no_grant", hold, 0);
    push(1'b0, 2'b10, 8'h05, 8'h00, 8'hFA);
    req0 = 1'b0;
    @(negedge CLK);
    req0 = 1'b1;
    wait_done(1'b0, 100);
    req0 = 1'b0;
    wait_idle(50);

    // reset in the middle of a read
    model_lat = 1000;
    rw0 = 1'b1; addr0 = 8'h00;
    push(1'b0, 2'b10, 8'h00, 8'h00, 8'h12);
    req0 = 1'b1;
    for (int n = 0; n < 50 && iic_start != 2'b10; n++) @(negedge CLK);
    check("midwait_start", iic_start, 2'b10);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("async_rst_start", iic_start, 2'b00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", {30'd0, done1, done0}, 32'd0);
    check("async_rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
    req0 = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // hard time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "time limit");
  end

endmodule
